segment_transition: RTL and testbench

- Decides which memory segment (0/1) the modulation or STM sampler reads, and when that segment changes.
- Sits directly downstream of the controller register file and upstream of the sampler/index generator.
- Consumes the latched req-segment, repeat-count, transition-mode and transition-value registers.
- Produces the active segment, a swap strobe, and a stop flag for finite-repeat playback.
- Instanced once for modulation and once for STM.

---
 rtl/segment_transition_pkg.sv | 31 +++
 rtl/segment_transition_if.sv | 34 +++
 rtl/segment_transition_gpio_sync_edge.sv | 26 ++
 rtl/segment_transition.sv | 136 +++++++++++++
 tb/tb_segment_transition.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/segment_transition_pkg.sv
// Shared types and constants for the segment transition controller.
// Mode encodings match the controller register file's transition_mode_t.
package segment_transition_pkg;

  localparam int RepWidthDef        = 16;
  localparam int SysTimeWidthDef    = 56;
  localparam int TransValueWidthDef = 64;

  localparam logic [RepWidthDef-1:0] RepInfinite = '1;

  typedef enum logic [7:0] {
    MODE_SYNC_IDX = 8'h00,
    MODE_SYS_TIME = 8'h01,
    MODE_GPIO     = 8'h02,
    MODE_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    WAIT_TIME,
    WAIT_GPIO,
    EXT_RUN
  } transition_state_t;

  function automatic logic is_known_mode(input logic [7:0] mode);
    return (mode == MODE_SYNC_IDX) || (mode == MODE_SYS_TIME) ||
           (mode == MODE_GPIO)     || (mode == MODE_EXT);
  endfunction

endpackage

// File: rtl/segment_transition_if.sv
// Request/status bundle between the controller register file (master)
// and the segment transition block (slave).
interface segment_transition_if #(
  parameter int RepWidth        = 16,
  parameter int SysTimeWidth    = 56,
  parameter int TransValueWidth = 64
);
  logic                       UPDATE;
  logic                       REQ_SEGMENT;
  logic [7:0]                 TRANSITION_MODE;
  logic [TransValueWidth-1:0] TRANSITION_VALUE;
  logic [RepWidth-1:0]        REP0;
  logic [RepWidth-1:0]        REP1;
  logic [SysTimeWidth-1:0]    SYS_TIME;
  logic [1:0]                 SYNC_IDX_ZERO;
  logic                       LOOP_END;
  logic [3:0]                 GPIO_IN;
  logic                       SEGMENT;
  logic                       SWAPPED;
  logic                       STOP;
  logic [RepWidth-1:0]        LOOP_CNT;

  modport master (
    output UPDATE, REQ_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE, REP0, REP1,
           SYS_TIME, SYNC_IDX_ZERO, LOOP_END, GPIO_IN,
    input  SEGMENT, SWAPPED, STOP, LOOP_CNT
  );

  modport slave (
    input  UPDATE, REQ_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE, REP0, REP1,
           SYS_TIME, SYNC_IDX_ZERO, LOOP_END, GPIO_IN,
    output SEGMENT, SWAPPED, STOP, LOOP_CNT
  );
endinterface

// File: rtl/segment_transition_gpio_sync_edge.sv
// Two-flop synchroniser for the asynchronous GPIO inputs plus a rising-edge
// detector; o_rise is combinational from the synchronised and previous bits.
module gpio_sync_edge (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] i_gpio,
  output logic [3:0] o_rise
);
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_prev;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_gpio;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;
endmodule

// File: rtl/segment_transition.sv
// Chooses the active memory segment and when it changes: deferred swaps on
// sync/time/GPIO triggers, immediate swap plus auto-alternation in EXT mode.
module segment_transition
  import segment_transition_pkg::*;
#(
  parameter int RepWidth        = RepWidthDef,
  parameter int SysTimeWidth    = SysTimeWidthDef,
  parameter int TransValueWidth = TransValueWidthDef
) (
  input logic                 CLK,
  input logic                 RST_N,
  segment_transition_if.slave bus
);
  localparam logic [RepWidth-1:0] RepAllOnes = '1;

  transition_state_t       r_state;
  transition_state_t       w_state_next;
  logic                    r_req_seg;
  logic [7:0]              r_mode;
  logic [SysTimeWidth-1:0] r_time_target;
  logic [1:0]              r_gpio_sel;
  logic                    r_segment, w_segment_next;
  logic                    r_swapped, w_swapped_next;
  logic                    r_stop, w_stop_next;
  logic [RepWidth-1:0]     r_loop_cnt, w_loop_cnt_next;

  logic                    w_update_ok;
  logic                    w_trigger;
  logic [3:0]              w_gpio_rise;
  logic [RepWidth-1:0]     w_rep_cur;
  logic                    w_rep_finite;
  logic                    w_at_rep;
  logic [RepWidth-1:0]     w_cnt_inc;

  gpio_sync_edge u_gpio_sync_edge (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_gpio (bus.GPIO_IN),
    .o_rise (w_gpio_rise)
  );

  assign w_update_ok  = bus.UPDATE && is_known_mode(bus.TRANSITION_MODE);
  assign w_rep_cur    = r_segment ? bus.REP1 : bus.REP0;
  assign w_rep_finite = (w_rep_cur != RepAllOnes);
  assign w_at_rep     = w_rep_finite && (r_loop_cnt == w_rep_cur);
  assign w_cnt_inc    = (r_loop_cnt == RepAllOnes) ? r_loop_cnt : r_loop_cnt + 1'b1;

  always_comb begin
    w_trigger = 1'b0;
    case (r_state)
      WAIT_SYNC: w_trigger = bus.SYNC_IDX_ZERO[r_req_seg];
      WAIT_TIME: w_trigger = (bus.SYS_TIME >= r_time_target);
      WAIT_GPIO: w_trigger = w_gpio_rise[r_gpio_sel];
      default:   w_trigger = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= IDLE;
      r_req_seg     <= 1'b0;
      r_mode        <= 8'h00;
      r_time_target <= '0;
      r_gpio_sel    <= 2'd0;
      r_segment     <= 1'b0;
      r_swapped     <= 1'b0;
      r_stop        <= 1'b0;
      r_loop_cnt    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_segment  <= w_segment_next;
      r_swapped  <= w_swapped_next;
      r_stop     <= w_stop_next;
      r_loop_cnt <= w_loop_cnt_next;
      if (w_update_ok) begin
        r_req_seg     <= bus.REQ_SEGMENT;
        r_mode        <= bus.TRANSITION_MODE;
        r_time_target <= bus.TRANSITION_VALUE[SysTimeWidth-1:0];
        r_gpio_sel    <= bus.TRANSITION_VALUE[1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_update_ok) begin
      case (bus.TRANSITION_MODE)
        MODE_SYNC_IDX: w_state_next = WAIT_SYNC;
        MODE_SYS_TIME: w_state_next = WAIT_TIME;
        MODE_GPIO:     w_state_next = WAIT_GPIO;
        default:       w_state_next = EXT_RUN;
      endcase
    end else if (w_trigger) begin
      w_state_next = IDLE;
    end
  end

  // A valid UPDATE masks any trigger in the same cycle; only EXT swaps at once.
  always_comb begin
    w_segment_next  = r_segment;
    w_swapped_next  = 1'b0;
    w_stop_next     = r_stop;
    w_loop_cnt_next = r_loop_cnt;
    if (w_update_ok) begin
      if (bus.TRANSITION_MODE == MODE_EXT) begin
        w_segment_next  = bus.REQ_SEGMENT;
        w_swapped_next  = 1'b1;
        w_stop_next     = 1'b0;
        w_loop_cnt_next = '0;
      end
    end else if (w_trigger) begin
      w_segment_next  = r_req_seg;
      w_swapped_next  = 1'b1;
      w_stop_next     = 1'b0;
      w_loop_cnt_next = '0;
    end else if (bus.LOOP_END) begin
      if (r_state == IDLE && !r_stop) begin
        if (w_at_rep) w_stop_next = 1'b1;
        else          w_loop_cnt_next = w_cnt_inc;
      end else if (r_state == EXT_RUN) begin
        if (w_at_rep) begin
          w_segment_next  = ~r_segment;
          w_swapped_next  = 1'b1;
          w_loop_cnt_next = '0;
        end else begin
          w_loop_cnt_next = w_cnt_inc;
        end
      end
    end
  end

  assign bus.SEGMENT  = r_segment;
  assign bus.SWAPPED  = r_swapped;
  assign bus.STOP     = r_stop;
  assign bus.LOOP_CNT = r_loop_cnt;
endmodule

// File: tb/tb_segment_transition.sv
// Directed bench for segment_transition: each stimulus step is applied before
// a rising edge and outputs are checked 1 ns after it.
module tb_segment_transition;
  import segment_transition_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   errors = 0;
  int   checks = 0;

  segment_transition_if bus ();

  segment_transition dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_update(input logic req, input logic [7:0] mode, input logic [63:0] value);
    $display("update req=%0d mode=0x%02h value=%0d", req, mode, value);
    bus.REQ_SEGMENT      = req;
    bus.TRANSITION_MODE  = mode;
    bus.TRANSITION_VALUE = value;
    bus.UPDATE           = 1'b1;
    step();
    bus.UPDATE = 1'b0;
  endtask

  task automatic loop_end_pulse();
    bus.LOOP_END = 1'b1;
    step();
    bus.LOOP_END = 1'b0;
  endtask

  logic exp_seg[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic exp_swp[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    bus.UPDATE = 0; bus.REQ_SEGMENT = 0; bus.TRANSITION_MODE = 8'h00;
    bus.TRANSITION_VALUE = '0; bus.REP0 = RepInfinite; bus.REP1 = RepInfinite;
    bus.SYS_TIME = '0; bus.SYNC_IDX_ZERO = 2'b00; bus.LOOP_END = 0; bus.GPIO_IN = 4'h0;
    repeat (3) step();
    RST_N = 1'b1;
    step();
    check("reset_segment", 64'(bus.SEGMENT), 64'd0);
    check("reset_stop", 64'(bus.STOP), 64'd0);
    check("reset_loop_cnt", 64'(bus.LOOP_CNT), 64'd0);
    check("reset_swapped", 64'(bus.SWAPPED), 64'd0);

    // SYNC_IDX: wrong-segment sync pulse must not fire
    do_update(1'b1, 8'h00, 64'd0);
    repeat (9) step();
    bus.SYNC_IDX_ZERO = 2'b01; step(); bus.SYNC_IDX_ZERO = 2'b00;
    check("sync_hold_seg", 64'(bus.SEGMENT), 64'd0);
    bus.SYNC_IDX_ZERO = 2'b10; step(); bus.SYNC_IDX_ZERO = 2'b00;
    check("sync_swap_seg", 64'(bus.SEGMENT), 64'd1);
    check("sync_swapped", 64'(bus.SWAPPED), 64'd1);
    step();
    check("sync_swapped_1cyc", 64'(bus.SWAPPED), 64'd0);

    // SYS_TIME ramp to target 1000
    bus.SYS_TIME = 56'd990;
    do_update(1'b0, 8'h01, 64'd1000);
    for (int t = 991; t < 1000; t++) begin
      bus.SYS_TIME = 56'(t);
      step();
    end
    check("time_before_seg", 64'(bus.SEGMENT), 64'd1);
    bus.SYS_TIME = 56'd1000; step();
    check("time_swap_seg", 64'(bus.SEGMENT), 64'd0);
    check("time_swapped", 64'(bus.SWAPPED), 64'd1);

    // target already in the past
    bus.SYS_TIME = 56'd900;
    do_update(1'b1, 8'h01, 64'd5);
    check("past_update_seg", 64'(bus.SEGMENT), 64'd0);
    step();
    check("past_swap_seg", 64'(bus.SEGMENT), 64'd1);
    check("past_swapped", 64'(bus.SWAPPED), 64'd1);

    // GPIO select 2: activity on GPIO 0 is ignored
    do_update(1'b0, 8'h02, 64'd2);
    bus.GPIO_IN = 4'b0001; repeat (5) step();
    bus.GPIO_IN = 4'b0000; repeat (3) step();
    check("gpio_other_pin", 64'(bus.SEGMENT), 64'd1);
    bus.GPIO_IN = 4'b0100;
    step(); check("gpio_e1_seg", 64'(bus.SEGMENT), 64'd1);
    step(); check("gpio_e2_seg", 64'(bus.SEGMENT), 64'd1);
    step(); check("gpio_e3_seg", 64'(bus.SEGMENT), 64'd0);
    check("gpio_swapped", 64'(bus.SWAPPED), 64'd1);
    bus.GPIO_IN = 4'b0000;

    // finite repeat REP1=2 -> three loops then STOP
    bus.REP1 = 16'd2;
    do_update(1'b1, 8'h00, 64'd0);
    bus.SYNC_IDX_ZERO = 2'b10; step(); bus.SYNC_IDX_ZERO = 2'b00;
    check("rep_swap_seg", 64'(bus.SEGMENT), 64'd1);
    loop_end_pulse(); step();
    loop_end_pulse(); step();
    check("rep_stop_early", 64'(bus.STOP), 64'd0);
    check("rep_cnt_2", 64'(bus.LOOP_CNT), 64'd2);
    loop_end_pulse(); step();
    check("rep_stop_set", 64'(bus.STOP), 64'd1);
    check("rep_cnt_held", 64'(bus.LOOP_CNT), 64'd2);
    loop_end_pulse(); step();
    check("rep_4th_ignored_cnt", 64'(bus.LOOP_CNT), 64'd2);
    check("rep_4th_stop", 64'(bus.STOP), 64'd1);

    // infinite repeat: restart clears STOP, counter saturates
    bus.REP1 = RepInfinite;
    do_update(1'b1, 8'h00, 64'd0);
    bus.SYNC_IDX_ZERO = 2'b10; step(); bus.SYNC_IDX_ZERO = 2'b00;
    check("restart_stop_clr", 64'(bus.STOP), 64'd0);
    check("restart_swapped", 64'(bus.SWAPPED), 64'd1);
    $display("loop_end x70000 on infinite repeat");
    bus.LOOP_END = 1'b1; repeat (70000) step(); bus.LOOP_END = 1'b0;
    check("inf_cnt_sat", 64'(bus.LOOP_CNT), 64'hFFFF);
    check("inf_no_stop", 64'(bus.STOP), 64'd0);

    // EXT alternation with REP0=1, REP1=0
    bus.REP0 = 16'd1; bus.REP1 = 16'd0;
    do_update(1'b0, 8'hF0, 64'd0);
    check("ext_seg0", 64'(bus.SEGMENT), 64'd0);
    check("ext_swapped0", 64'(bus.SWAPPED), 64'd1);
    for (int i = 0; i < 5; i++) begin
      loop_end_pulse();
      $display("ext loop_end %0d seg=%0d swapped=%0d", i, bus.SEGMENT, bus.SWAPPED);
      check($sformatf("ext_seg_%0d", i), 64'(bus.SEGMENT), 64'(exp_seg[i]));
      check($sformatf("ext_swp_%0d", i), 64'(bus.SWAPPED), 64'(exp_swp[i]));
      check($sformatf("ext_stop_%0d", i), 64'(bus.STOP), 64'd0);
      step();
    end

    // UPDATE coincident with trigger for the old request
    do_update(1'b0, 8'h00, 64'd0);
    bus.SYNC_IDX_ZERO = 2'b01;
    do_update(1'b1, 8'h00, 64'd0);
    bus.SYNC_IDX_ZERO = 2'b00;
    check("coinc_seg", 64'(bus.SEGMENT), 64'd1);
    check("coinc_swapped", 64'(bus.SWAPPED), 64'd0);
    bus.SYNC_IDX_ZERO = 2'b01; step(); bus.SYNC_IDX_ZERO = 2'b00;
    check("coinc_old_dead", 64'(bus.SWAPPED), 64'd0);
    bus.SYNC_IDX_ZERO = 2'b10; step(); bus.SYNC_IDX_ZERO = 2'b00;
    check("same_seg_restart_seg", 64'(bus.SEGMENT), 64'd1);
    check("same_seg_restart_swp", 64'(bus.SWAPPED), 64'd1);

    // unknown mode 0x07 leaves the pending time request intact
    bus.SYS_TIME = 56'd0;
    do_update(1'b0, 8'h01, 64'd2000);
    do_update(1'b1, 8'h07, 64'd0);
    check("bad_mode_seg", 64'(bus.SEGMENT), 64'd1);
    check("bad_mode_swp", 64'(bus.SWAPPED), 64'd0);
    bus.SYS_TIME = 56'd2000; step();
    check("bad_mode_old_fires", 64'(bus.SEGMENT), 64'd0);
    check("bad_mode_old_swp", 64'(bus.SWAPPED), 64'd1);

    // async reset while waiting on time
    do_update(1'b1, 8'hF0, 64'd0);
    check("pre_rst_seg", 64'(bus.SEGMENT), 64'd1);
    bus.SYS_TIME = 56'd0;
    do_update(1'b1, 8'h01, 64'd3000);
    RST_N = 1'b0;
    #1;
    check("async_rst_seg", 64'(bus.SEGMENT), 64'd0);
    step();
    RST_N = 1'b1;
    step();
    bus.SYS_TIME = 56'd3000;
    repeat (3) step();
    check("post_rst_seg", 64'(bus.SEGMENT), 64'd0);
    check("post_rst_swp", 64'(bus.SWAPPED), 64'd0);
    check("post_rst_stop", 64'(bus.STOP), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
